// File: rtl/cnn_pkg.sv
// ----------------------------------------------------------------------------
// cnn_pkg
// Shared types and helpers for the CNN pixel-stream stages.
//   pix_max      : unsigned max on PIX_MAX_W bits. Callers zero-extend their
//                  operands to PIX_MAX_W and cast the result back to their own
//                  pixel width, so one function serves every stage width
//                  (pixel widths up to PIX_MAX_W bits).
//   pool_phase_e : position of the current pixel inside a 2x2 pooling window,
//                  encoded as {row[0], col[0]}.
// ----------------------------------------------------------------------------
package cnn_pkg;

    localparam int PIX_MAX_W = 32;

    typedef enum logic [1:0] {
        EVEN_ROW_CAPTURE = 2'b00,
        EVEN_ROW_STORE   = 2'b01,
        ODD_ROW_READ     = 2'b10,
        ODD_ROW_EMIT     = 2'b11
    } pool_phase_e;

    function automatic logic [PIX_MAX_W-1:0] pix_max(
        input logic [PIX_MAX_W-1:0] a,
        input logic [PIX_MAX_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic pool_phase_e pool_phase(
        input logic row_odd,
        input logic col_odd
    );
        return pool_phase_e'({row_odd, col_odd});
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// ----------------------------------------------------------------------------
// pool_line_buffer
// Simple dual-port RAM holding the horizontal-pair maxima of one even row.
// Synchronous write, synchronous registered read, no reset, so it maps onto
// block RAM. Read data holds until the next read enable.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe
//   rd_addr  in   read address
//   rd_data  out  registered read data
// ----------------------------------------------------------------------------
module pool_line_buffer #(
    parameter int WORD_SIZE = 8,
    parameter int DEPTH     = 270,
    parameter int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [WORD_SIZE-1:0] rd_data
);

    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [WORD_SIZE-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/maxpool_2x2.sv
// ----------------------------------------------------------------------------
// maxpool_2x2
// Streaming 2x2 / stride-2 max-pooling of a raster-order pixel stream.
// Horizontal pair maxima of each even row are parked in a half-row line
// buffer and combined with the matching pair of the following odd row, so
// the stage runs in one pass at full input rate with no backpressure.
// Optional feature macro: MAXPOOL_RELU_EN
//   defined   : inputs are signed; negative pixels are clamped to 0 before
//               pairing, so the output is max(0, window max).
//   undefined : plain unsigned max.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   inputPixel   in   pixel from the convolution stage
//   inputValid   in   inputPixel accepted on this edge
//   outputPixel  out  pooled pixel (registered, holds between strobes)
//   outputValid  out  one-cycle strobe qualifying outputPixel
//   frameDone    out  one-cycle pulse with the last pooled pixel of a frame
//
// phase            | meaning
// EVEN_ROW_CAPTURE | even row, even col: latch pixel into pair register
// EVEN_ROW_STORE   | even row, odd col : write pair max to line buffer
// ODD_ROW_READ     | odd row, even col : latch pixel, start line-buffer read
// ODD_ROW_EMIT     | odd row, odd col  : emit max(pair max, line-buffer data)
// ----------------------------------------------------------------------------
module maxpool_2x2
    import cnn_pkg::*;
#(
    parameter int WORD_SIZE    = 8,
    parameter int ROW_SIZE     = 540,
    parameter int IMAGE_HEIGHT = 360
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] inputPixel,
    input  logic                 inputValid,
    output logic [WORD_SIZE-1:0] outputPixel,
    output logic                 outputValid,
    output logic                 frameDone
);

    // One spare bit so the kept-extent bounds below are representable even
    // when the dimension is a power of two.
    localparam int COL_W     = $clog2(ROW_SIZE + 1);
    localparam int ROW_W     = $clog2(IMAGE_HEIGHT + 1);
    localparam int LB_DEPTH  = ROW_SIZE / 2;
    localparam int LB_ADDR_W = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int COL_KEEP  = (ROW_SIZE / 2) * 2;
    localparam int ROW_KEEP  = (IMAGE_HEIGHT / 2) * 2;

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(ROW_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_KEEP_B    = COL_W'(COL_KEEP);
    localparam logic [ROW_W-1:0] ROW_KEEP_B    = ROW_W'(ROW_KEEP);
    localparam logic [COL_W-1:0] COL_LAST_WIN  = COL_W'(COL_KEEP - 1);
    localparam logic [ROW_W-1:0] ROW_LAST_WIN  = ROW_W'(ROW_KEEP - 1);

    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [WORD_SIZE-1:0] pair_q, pair_d;
    logic [WORD_SIZE-1:0] out_pix_q, out_pix_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_done_q, frame_done_d;

    logic [WORD_SIZE-1:0] pix_in;
    logic [WORD_SIZE-1:0] pair_max;
    logic [WORD_SIZE-1:0] window_max;
    logic [WORD_SIZE-1:0] lb_rd_data;
    logic [LB_ADDR_W-1:0] lb_addr;
    logic                 lb_wr_en;
    logic                 lb_rd_en;
    logic                 in_window;
    logic                 last_window;
    pool_phase_e          phase;

`ifdef MAXPOOL_RELU_EN
    // Clamping up front keeps every later comparison on non-negative values,
    // so the unsigned pix_max stays correct for signed input.
    assign pix_in = inputPixel[WORD_SIZE-1] ? '0 : inputPixel;
`else
    assign pix_in = inputPixel;
`endif

    assign pair_max   = WORD_SIZE'(pix_max(PIX_MAX_W'(pair_q), PIX_MAX_W'(pix_in)));
    assign window_max = WORD_SIZE'(pix_max(PIX_MAX_W'(pair_max), PIX_MAX_W'(lb_rd_data)));

    assign phase       = pool_phase(row_q[0], col_q[0]);
    // The trailing column/row of an odd dimension falls outside every window.
    assign in_window   = (col_q < COL_KEEP_B) && (row_q < ROW_KEEP_B);
    assign last_window = (col_q == COL_LAST_WIN) && (row_q == ROW_LAST_WIN);
    // Reads happen only on odd rows and writes only on even rows, so one
    // address serves both ports without collision.
    assign lb_addr     = LB_ADDR_W'(col_q >> 1);

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        out_pix_d    = out_pix_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_wr_en     = 1'b0;
        lb_rd_en     = 1'b0;

        if (inputValid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (in_window) begin
                unique case (phase)
                    EVEN_ROW_CAPTURE: begin
                        pair_d = pix_in;
                    end
                    EVEN_ROW_STORE: begin
                        lb_wr_en = 1'b1;
                    end
                    ODD_ROW_READ: begin
                        pair_d   = pix_in;
                        lb_rd_en = 1'b1;
                    end
                    ODD_ROW_EMIT: begin
                        out_pix_d    = window_max;
                        out_valid_d  = 1'b1;
                        frame_done_d = last_window;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            out_pix_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_q       <= pair_d;
            out_pix_q    <= out_pix_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    pool_line_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (LB_DEPTH),
        .ADDR_W    (LB_ADDR_W)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .wr_addr (lb_addr),
        .wr_data (pair_max),
        .rd_en   (lb_rd_en),
        .rd_addr (lb_addr),
        .rd_data (lb_rd_data)
    );

    assign outputPixel = out_pix_q;
    assign outputValid = out_valid_q;
    assign frameDone   = frame_done_q;

endmodule

// File: tb/tb_maxpool_2x2.sv
module tb_maxpool_2x2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_pix, in5_pix;
    logic       in_valid, in5_valid;
    logic [7:0] out_pix, out5_pix;
    logic       out_valid, out5_valid;
    logic       fd, fd5;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    maxpool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(4), .IMAGE_HEIGHT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .inputPixel  (in_pix),
        .inputValid  (in_valid),
        .outputPixel (out_pix),
        .outputValid (out_valid),
        .frameDone   (fd)
    );

    maxpool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(5), .IMAGE_HEIGHT(5)) dut5 (
        .clk         (clk),
        .rst         (rst),
        .inputPixel  (in5_pix),
        .inputValid  (in5_valid),
        .outputPixel (out5_pix),
        .outputValid (out5_valid),
        .frameDone   (fd5)
    );

    task automatic drive(input logic v, input logic [7:0] p);
        @(negedge clk);
        in_valid = v;
        in_pix   = p;
        @(posedge clk);
        #1;
    endtask

    task automatic drive5(input logic v, input logic [7:0] p);
        @(negedge clk);
        in5_valid = v;
        in5_pix   = p;
        @(posedge clk);
        #1;
    endtask

    // Hand-computed 4x4 ramp frame (pixel i = i+1): windows give 6,8,14,16.
    function automatic void ramp_exp(input int i, output logic ev,
                                     output logic [7:0] ep, output logic ef);
        ev = 1'b0;
        ep = 8'd0;
        ef = 1'b0;
        case (i)
            5:  begin ev = 1'b1; ep = 8'd6;  end
            7:  begin ev = 1'b1; ep = 8'd8;  end
            13: begin ev = 1'b1; ep = 8'd14; end
            15: begin ev = 1'b1; ep = 8'd16; ef = 1'b1; end
            default: ;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_pix = 8'h00;
        in5_valid = 1'b0; in5_pix = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vectors++;
        if (out_pix !== 8'h00) begin errors++; $display("FAIL reset_pixel got %h want 00", out_pix); end
        vectors++;
        if (fd !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", fd); end
        vectors++;
        if (out5_valid !== 1'b0 || out5_pix !== 8'h00 || fd5 !== 1'b0) begin
            errors++; $display("FAIL reset_dut5 got v=%b p=%h fd=%b want 0/00/0", out5_valid, out5_pix, fd5);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        logic ev, ef; logic [7:0] ep; int n = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i + 1));
            ramp_exp(i, ev, ep, ef);
            vectors++;
            if (out_valid !== ev) begin errors++; $display("FAIL ramp_valid[%0d] got %b want %b", i, out_valid, ev); end
            if (ev) begin
                n++;
                vectors++;
                if (out_pix !== ep) begin errors++; $display("FAIL ramp_pixel[%0d] got %0d want %0d", i, out_pix, ep); end
            end
            vectors++;
            if (fd !== ef) begin errors++; $display("FAIL ramp_frame_done[%0d] got %b want %b", i, fd, ef); end
        end
        drive(1'b0, 8'h00);
        vectors++;
        if (out_valid !== 1'b0 || fd !== 1'b0) begin errors++; $display("FAIL ramp_idle got v=%b fd=%b want 0/0", out_valid, fd); end
        vectors++;
        if (n != 4) begin errors++; $display("FAIL ramp_count got %0d want 4", n); end
    endtask

    task automatic test_bubbles();
        logic ev, ef; logic [7:0] ep; logic [7:0] held = 8'd16;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i + 1));
            ramp_exp(i, ev, ep, ef);
            if (ev) held = ep;
            vectors++;
            if (out_valid !== ev) begin errors++; $display("FAIL bubble_valid[%0d] got %b want %b", i, out_valid, ev); end
            vectors++;
            if (out_pix !== held) begin errors++; $display("FAIL bubble_pixel[%0d] got %0d want %0d", i, out_pix, held); end
            vectors++;
            if (fd !== ef) begin errors++; $display("FAIL bubble_frame_done[%0d] got %b want %b", i, fd, ef); end
            // Garbage on the bus during a bubble must be ignored.
            drive(1'b0, 8'hAA);
            vectors++;
            if (out_valid !== 1'b0 || fd !== 1'b0) begin
                errors++; $display("FAIL bubble_gap[%0d] got v=%b fd=%b want 0/0", i, out_valid, fd);
            end
            vectors++;
            if (out_pix !== held) begin errors++; $display("FAIL bubble_hold[%0d] got %0d want %0d", i, out_pix, held); end
        end
    endtask

    task automatic test_odd_dims();
        logic ev, ef; int n = 0;
        for (int i = 0; i < 25; i++) begin
            drive5(1'b1, ((i / 5) == 4 || (i % 5) == 4) ? 8'hFF : 8'h10);
            ev = (i == 6 || i == 8 || i == 16 || i == 18);
            ef = (i == 18);
            vectors++;
            if (out5_valid !== ev) begin errors++; $display("FAIL odd_valid[%0d] got %b want %b", i, out5_valid, ev); end
            if (ev) begin
                n++;
                vectors++;
                if (out5_pix !== 8'h10) begin errors++; $display("FAIL odd_pixel[%0d] got %h want 10", i, out5_pix); end
            end
            vectors++;
            if (fd5 !== ef) begin errors++; $display("FAIL odd_frame_done[%0d] got %b want %b", i, fd5, ef); end
        end
        drive5(1'b0, 8'h00);
        vectors++;
        if (n != 4) begin errors++; $display("FAIL odd_count got %0d want 4", n); end
    endtask

    task automatic test_relu();
        logic [7:0] p; logic ev; logic [7:0] ep;
`ifdef MAXPOOL_RELU_EN
        logic [7:0] first_exp = 8'h7F;
`else
        logic [7:0] first_exp = 8'h80;
`endif
        for (int i = 0; i < 16; i++) begin
            case (i)
                0: p = 8'h80;
                1: p = 8'h7F;
                4: p = 8'h01;
                default: p = 8'h00;
            endcase
            drive(1'b1, p);
            ev = (i == 5 || i == 7 || i == 13 || i == 15);
            ep = (i == 5) ? first_exp : 8'h00;
            vectors++;
            if (out_valid !== ev) begin errors++; $display("FAIL relu_valid[%0d] got %b want %b", i, out_valid, ev); end
            if (ev) begin
                vectors++;
                if (out_pix !== ep) begin errors++; $display("FAIL relu_pixel[%0d] got %h want %h", i, out_pix, ep); end
            end
        end
        drive(1'b0, 8'h00);
    endtask

    task automatic test_reset_midframe();
        logic ev, ef; logic [7:0] ep;
        for (int i = 0; i < 6; i++) drive(1'b1, 8'(i + 1));
        vectors++;
        if (out_pix !== 8'd6) begin errors++; $display("FAIL midframe_pre got %0d want 6", out_pix); end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_pix !== 8'h00 || out_valid !== 1'b0 || fd !== 1'b0) begin
            errors++; $display("FAIL midframe_async got p=%h v=%b fd=%b want 00/0/0", out_pix, out_valid, fd);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out_pix !== 8'h00 || out_valid !== 1'b0) begin
                errors++; $display("FAIL midframe_held[%0d] got p=%h v=%b want 00/0", k, out_pix, out_valid);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i + 1));
            ramp_exp(i, ev, ep, ef);
            vectors++;
            if (out_valid !== ev) begin errors++; $display("FAIL post_reset_valid[%0d] got %b want %b", i, out_valid, ev); end
            if (ev) begin
                vectors++;
                if (out_pix !== ep) begin errors++; $display("FAIL post_reset_pixel[%0d] got %0d want %0d", i, out_pix, ep); end
            end
            vectors++;
            if (fd !== ef) begin errors++; $display("FAIL post_reset_frame_done[%0d] got %b want %b", i, fd, ef); end
        end
    endtask

    task automatic test_back_to_back();
        logic ev, ef; logic [7:0] ep; int n = 0; int nfd = 0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 8'((i % 16) + 1));
            ramp_exp(i % 16, ev, ep, ef);
            if (out_valid === 1'b1) n++;
            if (fd === 1'b1) nfd++;
            vectors++;
            if (out_valid !== ev) begin errors++; $display("FAIL b2b_valid[%0d] got %b want %b", i, out_valid, ev); end
            if (ev) begin
                vectors++;
                if (out_pix !== ep) begin errors++; $display("FAIL b2b_pixel[%0d] got %0d want %0d", i, out_pix, ep); end
            end
        end
        drive(1'b0, 8'h00);
        vectors++;
        if (n != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", n); end
        vectors++;
        if (nfd != 2) begin errors++; $display("FAIL b2b_frame_done_count got %0d want 2", nfd); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_bubbles();
        test_odd_dims();
        test_relu();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
